approx_err_checker: RTL and testbench



---
 rtl/approx_err_checker.sv | 97 +++++++++
 tb/tb_approx_err_checker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/approx_err_checker.sv
// Exhaustive error-threshold checker for an approximate |a-b| circuit.
// Sweeps every input vector, compares against the exact result, and reports max error, count and first failure.
module approx_err_checker #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int ET    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W:0]   max_err,
    output logic [IN_W:0]    err_count,
    output logic             fail_valid,
    output logic [IN_W-1:0]  fail_vec
);
    localparam int W = IN_W / 2;
    localparam logic [OUT_W:0] ET_V = (OUT_W+1)'(ET);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FIN} state_t;

    state_t r_state, w_next;

    logic [W-1:0]   w_a, w_b, w_diff;
    logic [OUT_W:0] w_exact, w_out_ext, w_err;
    logic           w_last;

    assign w_a       = dut_in[W-1:0];
    assign w_b       = dut_in[IN_W-1:W];
    assign w_diff    = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    assign w_exact   = {{(OUT_W+1-W){1'b0}}, w_diff};
    assign w_out_ext = {1'b0, dut_out};
    assign w_err     = (w_out_ext >= w_exact) ? (w_out_ext - w_exact) : (w_exact - w_out_ext);
    assign w_last    = &dut_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRIVE;
            DRIVE:   w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? FIN : DRIVE;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            max_err    <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    dut_in     <= '0;
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                    max_err    <= '0;
                    err_count  <= '0;
                    fail_valid <= 1'b0;
                    fail_vec   <= '0;
                end
                SAMPLE: begin
                    if (w_err > max_err) max_err <= w_err;
                    if (w_err != '0) err_count <= err_count + (IN_W+1)'(1);
                    // Only the first over-threshold vector is latched.
                    if (w_err > ET_V && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_vec   <= dut_in;
                    end
                    if (!w_last) dut_in <= dut_in + IN_W'(1);
                end
                FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (max_err <= ET_V);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_err_checker.sv
// Scoreboarded random bench for approx_err_checker: a lookup-table DUT stand-in, a per-sweep reference model, and a done-triggered monitor.
module tb_approx_err_checker;
    localparam int IN_W  = 4;
    localparam int OUT_W = 3;
    localparam int ET    = 1;
    localparam int W     = IN_W / 2;
    localparam int NV    = 1 << IN_W;
    localparam int LAT   = 2 * NV + 1;

    typedef struct {
        int maxe;
        int cnt;
        int fv;
        int fvec;
        int pss;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
    logic             busy, done, pass, fail_valid;
    logic [OUT_W:0]   max_err;
    logic [IN_W:0]    err_count;
    logic [IN_W-1:0]  fail_vec;

    logic [OUT_W-1:0] tbl [NV];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    approx_err_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .max_err(max_err), .err_count(err_count),
        .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_out = tbl[dut_in];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exact_of(input int v);
        int a, b;
        a = v % (1 << W);
        b = v >> W;
        return (a >= b) ? a - b : b - a;
    endfunction

    // Reference: walk all vectors in order and accumulate the statistics directly.
    function automatic exp_t model();
        exp_t e;
        int   d;
        e = '{default: 0};
        for (int v = 0; v < NV; v++) begin
            d = int'(tbl[v]) - exact_of(v);
            if (d < 0) d = -d;
            if (d > e.maxe) e.maxe = d;
            if (d != 0) e.cnt++;
            if (d > ET && e.fv == 0) begin
                e.fv   = 1;
                e.fvec = v;
            end
        end
        e.pss = (e.maxe <= ET) ? 1 : 0;
        return e;
    endfunction

    // 0 exact, 1 stuck at 0, 2 exact+1, 3 exact except vector C -> 0, other: random outputs
    task automatic build_tbl(input int mode);
        for (int v = 0; v < NV; v++) begin
            case (mode)
                0: tbl[v] = OUT_W'(exact_of(v));
                1: tbl[v] = '0;
                2: tbl[v] = OUT_W'(exact_of(v) + 1);
                3: tbl[v] = (v == 12) ? '0 : OUT_W'(exact_of(v));
                default: tbl[v] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
            endcase
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_in"}, int'(dut_in), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_max_err"}, int'(max_err), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_fail_valid"}, int'(fail_valid), 0);
        chk({tag, "_fail_vec"}, int'(fail_vec), 0);
    endtask

    task automatic run_sweep(input int mode, input int repulse, input bit fin_pulse, input bit chk_clear);
        exp_t e;
        bit   seen;
        build_tbl(mode);
        @(negedge clk);
        start = 1'b1;
        e = model();
        e.cyc = cyc + 1 + LAT;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (chk_clear) begin
            chk("restart_done_cleared", int'(done), 0);
            chk("restart_busy", int'(busy), 1);
            chk("restart_max_err_cleared", int'(max_err), 0);
            chk("restart_err_count_cleared", int'(err_count), 0);
            chk("restart_fail_valid_cleared", int'(fail_valid), 0);
            chk("restart_dut_in", int'(dut_in), 0);
        end
        if (repulse > 0) begin
            repeat (repulse - 1) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("repulse_busy", int'(busy), 1);
        end
        if (fin_pulse) begin
            for (int k = 0; k < 200 && cyc < e.cyc - 1; k++) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("fin_start_ignored_busy", int'(busy), 0);
            chk("fin_start_ignored_done", int'(done), 1);
        end else begin
            seen = 1'b0;
            for (int k = 0; k < 4 * LAT && !seen; k++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("done_within_bound", int'(seen), 1);
            if (!seen) q.delete();
            @(negedge clk);
        end
    endtask

    initial begin : monitor
        bit   prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("max_err", int'(max_err), e.maxe);
                    chk("err_count", int'(err_count), e.cnt);
                    chk("fail_valid", int'(fail_valid), e.fv);
                    if (e.fv != 0) chk("fail_vec", int'(fail_vec), e.fvec);
                    chk("pass", int'(pass), e.pss);
                    chk("busy_at_done", int'(busy), 0);
                    chk("dut_in_holds_last", int'(dut_in), NV - 1);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        build_tbl(0);
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 0, 1'b0, 1'b0);
        run_sweep(1, 0, 1'b0, 1'b1);
        run_sweep(2, 0, 1'b0, 1'b1);
        run_sweep(3, 0, 1'b0, 1'b1);
        run_sweep(4, 10, 1'b0, 1'b1);
        run_sweep(4, 0, 1'b1, 1'b1);
        run_sweep(1, 0, 1'b0, 1'b1);

        // Abort mid-sweep: reset lands between clock edges.
        build_tbl(4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("abort");
        q.delete();
        repeat (2) @(negedge clk);
        chk_reset_vals("abort_hold");
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run_sweep(4, 0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
